// File: rtl/fetch_request_unit.sv
// fetch_request_unit: round-robin fetch arbiter between the per-warp ITS units and
// instruction memory. Tracks outstanding in-order fetches in a circular buffer and
// hands the returned instructions to the decoder in issue order.
// Optional build macro FETCH_REQUEST_UNIT_PERF_EN enables the issue/stall counters;
// without it both perf outputs are tied to zero.
module fetch_request_unit #(
    parameter int NumWarps       = 8,
    parameter int WarpWidth      = 32,
    parameter int PcWidth        = 32,
    parameter int InstrWidth     = 32,
    parameter int InflightDepth  = 4,
    parameter int WarpIdWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    parameter int SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumWarps-1:0]                warp_ready_i,
    input  logic [NumWarps*PcWidth-1:0]        warp_pc_i,
    input  logic [NumWarps*WarpWidth-1:0]      warp_act_mask_i,
    input  logic [NumWarps*SubwarpIdWidth-1:0] warp_subwarp_id_i,
    output logic [NumWarps-1:0]                warp_selected_o,
    output logic                               imem_req_valid_o,
    input  logic                               imem_req_ready_i,
    output logic [PcWidth-1:0]                 imem_req_addr_o,
    input  logic                               imem_rsp_valid_i,
    input  logic [InstrWidth-1:0]              imem_rsp_data_i,
    output logic                               dec_valid_o,
    input  logic                               dec_ready_i,
    output logic [WarpIdWidth-1:0]             dec_warp_id_o,
    output logic [SubwarpIdWidth-1:0]          dec_subwarp_id_o,
    output logic [PcWidth-1:0]                 dec_pc_o,
    output logic [WarpWidth-1:0]               dec_act_mask_o,
    output logic [InstrWidth-1:0]              dec_instr_o,
    output logic [31:0]                        perf_issued_o,
    output logic [31:0]                        perf_stall_o
);

    localparam int PtrW = (InflightDepth > 1) ? $clog2(InflightDepth) : 1;
    localparam int CntW = $clog2(InflightDepth + 1);
    localparam logic [CntW-1:0]        DEPTH_C   = CntW'(InflightDepth);
    localparam logic [PtrW-1:0]        LAST_PTR  = PtrW'(InflightDepth - 1);
    localparam logic [WarpIdWidth-1:0] LAST_WARP = WarpIdWidth'(NumWarps - 1);

    // Buffer control state (reset)
    logic [PtrW-1:0]          tail_ptr, fill_ptr, head_ptr;
    logic [CntW-1:0]          count;
    logic [WarpIdWidth-1:0]   rr_ptr;
    logic [InflightDepth-1:0] ent_valid, ent_filled;

    // Buffer payload (not reset; qualified by ent_valid/ent_filled)
    logic [WarpIdWidth-1:0]    ent_warp    [InflightDepth];
    logic [SubwarpIdWidth-1:0] ent_subwarp [InflightDepth];
    logic [PcWidth-1:0]        ent_pc      [InflightDepth];
    logic [WarpWidth-1:0]      ent_mask    [InflightDepth];
    logic [InstrWidth-1:0]     ent_instr   [InflightDepth];

    logic [WarpIdWidth-1:0] win_idx;
    logic                   any_ready, req_valid, issue, rsp_ok, fill, head_filled, drain;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PtrW'(1);
    endfunction

    // Round-robin search: first ready warp at or after rr_ptr, wrapping
    always_comb begin
        int c;
        logic found;
        c       = 0;
        found   = 1'b0;
        win_idx = rr_ptr;
        for (int i = 0; i < NumWarps; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NumWarps) c = c - NumWarps;
            if (!found && warp_ready_i[c]) begin
                found   = 1'b1;
                win_idx = WarpIdWidth'(c);
            end
        end
    end

    assign any_ready   = |warp_ready_i;
    assign req_valid   = any_ready && (count < DEPTH_C);
    assign issue       = req_valid && imem_req_ready_i;
    assign rsp_ok      = ent_valid[fill_ptr] && !ent_filled[fill_ptr];
    assign fill        = imem_rsp_valid_i && rsp_ok;
    assign head_filled = ent_filled[head_ptr];
    assign drain       = head_filled && dec_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = req_valid ? warp_pc_i[int'(win_idx)*PcWidth +: PcWidth] : '0;

    // One-hot grant only in the imem handshake cycle
    always_comb begin
        warp_selected_o = '0;
        if (issue) warp_selected_o[win_idx] = 1'b1;
    end

    assign dec_valid_o      = head_filled;
    assign dec_warp_id_o    = head_filled ? ent_warp[head_ptr]    : '0;
    assign dec_subwarp_id_o = head_filled ? ent_subwarp[head_ptr] : '0;
    assign dec_pc_o         = head_filled ? ent_pc[head_ptr]      : '0;
    assign dec_act_mask_o   = head_filled ? ent_mask[head_ptr]    : '0;
    assign dec_instr_o      = head_filled ? ent_instr[head_ptr]   : '0;

    // Pointers, occupancy and entry flags; issue/fill/drain never hit the same entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tail_ptr   <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            count      <= '0;
            rr_ptr     <= '0;
            ent_valid  <= '0;
            ent_filled <= '0;
        end else begin
            if (issue) begin
                tail_ptr            <= ptr_inc(tail_ptr);
                ent_valid[tail_ptr] <= 1'b1;
                rr_ptr              <= (win_idx == LAST_WARP) ? '0 : win_idx + WarpIdWidth'(1);
            end
            if (fill) begin
                ent_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= ptr_inc(fill_ptr);
            end
            if (drain) begin
                ent_valid[head_ptr]  <= 1'b0;
                ent_filled[head_ptr] <= 1'b0;
                head_ptr             <= ptr_inc(head_ptr);
            end
            count <= count + CntW'(issue) - CntW'(drain);
        end
    end

    // Entry payload capture at allocation and at response
    always_ff @(posedge clk_i) begin
        if (issue) begin
            ent_warp[tail_ptr]    <= win_idx;
            ent_subwarp[tail_ptr] <= warp_subwarp_id_i[int'(win_idx)*SubwarpIdWidth +: SubwarpIdWidth];
            ent_pc[tail_ptr]      <= warp_pc_i[int'(win_idx)*PcWidth +: PcWidth];
            ent_mask[tail_ptr]    <= warp_act_mask_i[int'(win_idx)*WarpWidth +: WarpWidth];
        end
        if (fill) ent_instr[fill_ptr] <= imem_rsp_data_i;
    end

`ifdef FETCH_REQUEST_UNIT_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    // Issued fetches and cycles where some warp waited without a handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue)              perf_issued_q <= perf_issued_q + 32'd1;
            if (any_ready && !issue) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_issued_o = '0;
    assign perf_stall_o  = '0;
`endif

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(warp_selected_o));
    a_grant_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        (warp_selected_o & ~warp_ready_i) == '0);
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= DEPTH_C);
    a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rsp_valid_i |-> rsp_ok);

endmodule
